// File: rtl/des_key_scheduler.sv
// rtl/des_key_scheduler.sv - DES key schedule sequencer streaming 16 PC-2 subkeys over valid/ready.
// Optional key parity check enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_scheduler #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} stateT;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:28] c, input logic [1:28] d);
    logic [1:56] cd;
    logic [1:48] r;
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
    return r;
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one place; all others by two.
  function automatic logic shiftIsTwo(input int n);
    return !(n == 1 || n == 2 || n == 9 || n == 16);
  endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic keyParityOk(input logic [1:64] k);
    logic ok;
    logic p;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      p = 1'b0;
      for (int j = 1; j <= 8; j++) p = p ^ k[8*b+j];
      if (!p) ok = 1'b0;
    end
    return ok;
  endfunction
`else
  logic unusedParityBits;
  assign unusedParityBits = ^{key[8], key[16], key[24], key[32],
                              key[40], key[48], key[56], key[64]};
`endif

  stateT       state, stateNext;
  logic [1:28] cReg, dReg, cNext, dNext;
  logic [3:0]  count, countNext;
  logic        decReg, decNext;
  logic [1:48] subkeyNext;
  logic        validNext, busyNext, doneNext, parityNext;
  logic        keyOk;
  logic        stepTwo;

  always_comb begin
`ifdef DES_KEY_PARITY_CHECK_EN
    keyOk = keyParityOk(key);
`else
    keyOk = 1'b1;
`endif
  end

  always_comb begin
    stateNext  = state;
    cNext      = cReg;
    dNext      = dReg;
    countNext  = count;
    decNext    = decReg;
    subkeyNext = subkey;
    validNext  = subkey_valid;
    busyNext   = busy;
    doneNext   = 1'b0;
    parityNext = parity_err;
    stepTwo    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          parityNext = !keyOk;
          if (keyOk) begin
            decNext        = decrypt;
            {cNext, dNext} = pc1(key);
            busyNext       = 1'b1;
            stateNext      = LOAD;
          end
        end
      end
      LOAD: begin
        // Decrypt starts from the unrotated halves, which already give K16.
        if (decReg) begin
          subkeyNext = pc2(cReg, dReg);
        end else begin
          stepTwo    = shiftIsTwo(1);
          cNext      = rotl(cReg, stepTwo);
          dNext      = rotl(dReg, stepTwo);
          subkeyNext = pc2(cNext, dNext);
        end
        validNext = 1'b1;
        countNext = '0;
        stateNext = RUN;
      end
      RUN: begin
        if (subkey_valid && subkey_ready) begin
          if (count == LAST) begin
            validNext = 1'b0;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
            stateNext = IDLE;
          end else begin
            countNext = count + 4'd1;
            // Decrypt undoes the encrypt rotations in reverse round order.
            if (decReg) begin
              stepTwo = shiftIsTwo(ROUNDS - int'(count));
              cNext   = rotr(cReg, stepTwo);
              dNext   = rotr(dReg, stepTwo);
            end else begin
              stepTwo = shiftIsTwo(int'(count) + 2);
              cNext   = rotl(cReg, stepTwo);
              dNext   = rotl(dReg, stepTwo);
            end
            subkeyNext = pc2(cNext, dNext);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cReg         <= '0;
      dReg         <= '0;
      count        <= '0;
      decReg       <= 1'b0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      state        <= stateNext;
      cReg         <= cNext;
      dReg         <= dNext;
      count        <= countNext;
      decReg       <= decNext;
      subkey       <= subkeyNext;
      subkey_valid <= validNext;
      busy         <= busyNext;
      done         <= doneNext;
      parity_err   <= parityNext;
    end
  end

  assign round = decReg ? (LAST - count) : count;

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb/tb_des_key_scheduler.sv - self-checking bench for des_key_scheduler against a DES schedule model.
module tb_des_key_scheduler;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1_A    = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_A    = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_A   = 48'hCB3D8B0E17F5;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
  } expT;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, subkey_ready;
  logic [1:64] key;
  logic [1:48] subkey;
  logic        subkey_valid, busy, done, parity_err;
  logic [3:0]  round;

  int   checks = 0;
  int   errors = 0;
  expT  q[$];
  logic pendingDone = 1'b0;
  logic parityExp = 1'b0;
  int   validCycles = 0;
  int   popped = 0;
  int   doneCount = 0;

  des_key_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
    .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .round(round), .busy(busy), .done(done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Kn computed from scratch: PC-1, cumulative rotation of both halves, PC-2.
  function automatic logic [47:0] subkeyOf(input logic [63:0] k, input int n);
    int tot;
    logic c0 [28];
    logic d0 [28];
    logic cd [56];
    logic [47:0] r;
    tot = 0;
    for (int i = 1; i <= n; i++) tot += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    for (int i = 0; i < 28; i++) begin
      c0[i] = k[64 - PC1_TAB[i]];
      d0[i] = k[64 - PC1_TAB[i+28]];
    end
    for (int i = 0; i < 28; i++) begin
      cd[i]    = c0[(i + tot) % 28];
      cd[i+28] = d0[(i + tot) % 28];
    end
    for (int j = 0; j < 48; j++) r[47-j] = cd[PC2_TAB[j] - 1];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushSchedule(input logic [63:0] k, input logic dec);
    expT e;
    for (int i = 0; i < 16; i++) begin
      e.sk  = dec ? subkeyOf(k, 16 - i) : subkeyOf(k, i + 1);
      e.rnd = dec ? 4'(15 - i) : 4'(i);
      q.push_back(e);
    end
  endtask

  task automatic startSeq(input logic [63:0] k, input logic dec);
    key     = k;
    decrypt = dec;
    start   = 1'b1;
    pushSchedule(k, dec);
    validCycles = 0;
    popped      = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 200);
    check("done_seen", done, 1);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!subkey_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("valid_seen", subkey_valid, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("done_pulse", done, pendingDone);
      check("parity_err", parity_err, parityExp);
      if (done) doneCount++;
      pendingDone = 1'b0;
      if (subkey_valid) begin
        validCycles++;
        check("busy_while_valid", busy, 1);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got subkey %h with no expected subkey", subkey);
        end else begin
          check("stream_subkey", subkey, q[0].sk);
          check("stream_round", round, q[0].rnd);
          if (subkey_ready) begin
            pendingDone = (q.size() == 1);
            void'(q.pop_front());
            popped++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1; key = KEY_A;
    repeat (2) @(posedge clk);
    #1;
    check("rst_subkey", subkey, 0);
    check("rst_valid", subkey_valid, 0);
    check("rst_round", round, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_parity", parity_err, 0);
    rst = 1'b0;

    check("model_k1", subkeyOf(KEY_A, 1), K1_A);
    check("model_k2", subkeyOf(KEY_A, 2), K2_A);
    check("model_k16", subkeyOf(KEY_A, 16), K16_A);

    // Encrypt with ready held high; first subkey two edges after start is raised.
    @(posedge clk); #1;
    startSeq(KEY_A, 1'b0);
    check("enc_busy_after_accept", busy, 1);
    check("enc_valid_in_load", subkey_valid, 0);
    @(posedge clk); #1;
    check("enc_first_valid", subkey_valid, 1);
    check("enc_first_k1", subkey, K1_A);
    check("enc_first_round", round, 0);
    @(posedge clk); #1;
    check("enc_second_k2", subkey, K2_A);
    waitDone();
    check("enc_no_bubbles", validCycles, 16);
    check("enc_popped", popped, 16);
    check("enc_busy_at_done", busy, 0);
    check("enc_valid_at_done", subkey_valid, 0);

    // Decrypt started in the same cycle done pulses.
    startSeq(KEY_A, 1'b1);
    @(posedge clk); #1;
    check("dec_first_k16", subkey, K16_A);
    check("dec_first_round", round, 15);
    waitDone();
    check("dec_popped", popped, 16);

    // Backpressure while K3 is presented.
    subkey_ready = 1'b0;
    startSeq(KEY_A, 1'b0);
    waitValid();
    subkey_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    subkey_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_subkey", subkey, subkeyOf(KEY_A, 3));
      check("bp_hold_round", round, 2);
      check("bp_hold_valid", subkey_valid, 1);
      @(posedge clk); #1;
    end
    subkey_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_resume_k4", subkey, subkeyOf(KEY_A, 4));
    check("bp_resume_round", round, 3);
    waitDone();

    // Asynchronous reset after K7 is accepted.
    startSeq(KEY_A, 1'b0);
    begin
      int n;
      n = 0;
      while (!(subkey_valid && round == 4'd7) && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("rst_mid_k8_shown", subkey, subkeyOf(KEY_A, 8));
    rst = 1'b1;
    q.delete();
    pendingDone = 1'b0;
    #1;
    check("rst_mid_subkey", subkey, 0);
    check("rst_mid_valid", subkey_valid, 0);
    check("rst_mid_round", round, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    doneCount = 0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid_no_done", doneCount, 0);
    startSeq(KEY_A, 1'b0);
    @(posedge clk); #1;
    check("rst_restart_k1", subkey, K1_A);
    waitDone();

    // start with another key during RUN is ignored.
    startSeq(KEY_A, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    key = KEY_B; decrypt = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    check("ignore_start_popped", popped, 16);
    check("ignore_start_queue_empty", q.size(), 0);

`ifdef DES_KEY_PARITY_CHECK_EN
    key = KEY_BAD; decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    parityExp = 1'b1;
    check("par_err_set", parity_err, 1);
    check("par_busy_low", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("par_no_valid", subkey_valid, 0);
    check("par_still_idle", busy, 0);
    startSeq(KEY_A, 1'b0);
    parityExp = 1'b0;
    check("par_err_cleared", parity_err, 0);
    check("par_good_busy", busy, 1);
    waitDone();
    check("par_good_popped", popped, 16);
`else
    check("model_parity_ignored", subkeyOf(KEY_BAD, 1), K1_A);
    startSeq(KEY_BAD, 1'b0);
    check("nopar_busy", busy, 1);
    waitDone();
    check("nopar_popped", popped, 16);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
